wavelet_filter_bank: RTL

- Parametrised successor to the fixed filter-bank top: a multi-scale Haar-style wavelet analyser on a streaming sample input.
- Each accepted sample shifts into a shared tap delay line. One time-multiplexed MAC engine then evaluates NUM_FILTERS filters of length BASE_LEN<<f and streams one tagged result per filter.
- Per-filter threshold detection replaces the old blinking-LED indicator. The block sits between the sample source and downstream scale/feature logic.

---
 rtl/wavelet_pkg.sv | 41 ++++
 rtl/wavelet_filter_bank_tap_delay_line.sv | 41 ++++
 rtl/wavelet_filter_bank.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wavelet_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wavelet_pkg
// Brief    : Shared types and sizing helpers for the Haar wavelet filter bank.
// Revision : 1.0 - initial release
// ============================================================================
package wavelet_pkg;

    // Controller states: waiting for a sample, or stepping the MAC engine.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    // Width of an index over n items, never less than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tap count of filter f.
    function automatic int filt_len(input int base_len, input int f);
        return base_len << f;
    endfunction

    // Cycles from sample acceptance until filter f's result is registered.
    function automatic int cum_len(input int base_len, input int f);
        int s;
        s = 0;
        for (int j = 0; j <= f; j++) begin
            s += base_len << j;
        end
        return s;
    endfunction

    // Result width that holds any +/- sum over max_len samples exactly.
    function automatic int res_bits(input int bits, input int max_len);
        return bits + $clog2(max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wavelet_filter_bank_tap_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tap_delay_line
// Brief    : Shift-enabled sample delay line with a combinational read port.
//            Tap 0 holds the newest sample.
// Revision : 1.0 - initial release
// ============================================================================
module tap_delay_line
    import wavelet_pkg::*;
#(
    parameter int BITS_PER_ELEM = 8,
    parameter int DEPTH         = 32
)(
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_shift,
    input  logic signed [BITS_PER_ELEM-1:0] i_data,
    input  logic [idx_bits(DEPTH)-1:0]      i_addr,
    output logic signed [BITS_PER_ELEM-1:0] o_data
);

    logic signed [BITS_PER_ELEM-1:0] r_line [DEPTH];

    // Shift the chain by one tap whenever a new sample is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
        end else if (i_shift) begin
            r_line[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_data = r_line[i_addr];

endmodule
`default_nettype wire

// File: rtl/wavelet_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : wavelet_filter_bank
// Brief    : Multi-scale Haar analyser. Each accepted sample triggers one
//            pass of a shared MAC engine over NUM_FILTERS filters of length
//            BASE_LEN<<f, emitting one tagged result and detect flag per scale.
// Revision : 1.0 - initial release
// ============================================================================
module wavelet_filter_bank
    import wavelet_pkg::*;
#(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_FILTERS   = 4,
    parameter int BASE_LEN      = 4,
    parameter int MAX_LEN       = BASE_LEN << (NUM_FILTERS - 1),
    parameter int RES_BITS      = res_bits(BITS_PER_ELEM, MAX_LEN),
    parameter int THRESHOLD     = 64
)(
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_valid,
    input  logic signed [BITS_PER_ELEM-1:0]    i_value,
    output logic                               o_ready,
    output logic                               o_valid,
    output logic [idx_bits(NUM_FILTERS)-1:0]   o_filter_idx,
    output logic signed [RES_BITS-1:0]         o_result,
    output logic [NUM_FILTERS-1:0]             o_detect
);

    localparam int c_k_w = idx_bits(MAX_LEN);
    localparam int c_f_w = idx_bits(NUM_FILTERS);
    localparam logic [c_f_w-1:0]  c_last_f = c_f_w'(NUM_FILTERS - 1);
    localparam logic [RES_BITS:0] c_thresh = (RES_BITS + 1)'(THRESHOLD);

    state_t                          r_state;
    logic [c_k_w-1:0]                r_k;
    logic [c_f_w-1:0]                r_f;
    logic signed [RES_BITS-1:0]      r_acc;
    logic                            r_ready;
    logic                            r_valid;
    logic [c_f_w-1:0]                r_filter_idx;
    logic signed [RES_BITS-1:0]      r_result;
    logic [NUM_FILTERS-1:0]          r_detect;

    logic                            w_accept;
    logic signed [BITS_PER_ELEM-1:0] w_tap;
    logic [c_k_w-1:0]                w_last;
    logic [c_k_w-1:0]                w_half;
    logic signed [RES_BITS-1:0]      w_ext;
    logic signed [RES_BITS-1:0]      w_term;
    logic signed [RES_BITS-1:0]      w_sum;
    logic signed [RES_BITS:0]        w_sum_wide;
    logic [RES_BITS:0]               w_mag;
    logic                            w_hit;

    assign w_accept = i_valid & r_ready;

    tap_delay_line #(
        .BITS_PER_ELEM (BITS_PER_ELEM),
        .DEPTH         (MAX_LEN)
    ) u_tap_delay_line (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_shift (w_accept),
        .i_data  (i_value),
        .i_addr  (r_k),
        .o_data  (w_tap)
    );

    // Current filter geometry, next accumulator value and its threshold test;
    // the magnitude is taken one bit wider so negating the most negative sum
    // cannot wrap.
    always_comb begin
        w_last     = c_k_w'(filt_len(BASE_LEN, int'(r_f)) - 1);
        w_half     = c_k_w'(filt_len(BASE_LEN, int'(r_f)) / 2);
        w_ext      = {{(RES_BITS - BITS_PER_ELEM){w_tap[BITS_PER_ELEM-1]}}, w_tap};
        w_term     = (r_k < w_half) ? w_ext : -w_ext;
        w_sum      = r_acc + w_term;
        w_sum_wide = {w_sum[RES_BITS-1], w_sum};
        w_mag      = w_sum_wide[RES_BITS] ? unsigned'(-w_sum_wide) : unsigned'(w_sum_wide);
        w_hit      = (w_mag > c_thresh);
    end

    // Controller: accept a sample in IDLE, then one MAC term per cycle,
    // publishing each filter's sum on its final term.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_f          <= '0;
            r_acc        <= '0;
            r_ready      <= 1'b1;
            r_valid      <= 1'b0;
            r_filter_idx <= '0;
            r_result     <= '0;
            r_detect     <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= MAC;
                        r_k     <= '0;
                        r_f     <= '0;
                        r_acc   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                MAC: begin
                    if (r_k == w_last) begin
                        r_result      <= w_sum;
                        r_filter_idx  <= r_f;
                        r_valid       <= 1'b1;
                        r_detect[r_f] <= w_hit;
                        r_acc         <= '0;
                        r_k           <= '0;
                        if (r_f == c_last_f) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_f <= r_f + c_f_w'(1);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + c_k_w'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_valid      = r_valid;
    assign o_filter_idx = r_filter_idx;
    assign o_result     = r_result;
    assign o_detect     = r_detect;

endmodule
`default_nettype wire
